// File: rtl/my_seq_adder.sv
// my_seq_adder: multi-cycle ripple adder/subtractor.
// One DIGIT-bit slice is added per clock (LSB slice first); the carry between
// slices lives in a register. Each slice is a ripple of full adders built from
// the my_xor / my_and / my_or library cells. start/busy/done handshake.

// Two-input XOR library cell.
module my_xor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// Two-input AND library cell.
module my_and (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// Two-input OR library cell.
module my_or (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module my_seq_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    // Counter is at least one bit wide so the N=1 case still elaborates.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;

    logic [DIGIT-1:0]   a_slice_s;
    logic [DIGIT-1:0]   b_slice_s;
    logic [DIGIT-1:0]   slice_sum_s;
    logic [DIGIT:0]     chain_s;
    logic               ovf_s;
    logic               last_s;
    logic               accept_s;

    // A new operation is taken only when no slices are in flight.
    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign last_s   = (cnt_r == CW'(N - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: RUN for N slices, DONE for one cycle, back-to-back from DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Select the operand slice addressed by the counter (AND-OR mux, constant indices).
    always_comb begin
        a_slice_s = {DIGIT{1'b0}};
        b_slice_s = {DIGIT{1'b0}};
        for (int j = 0; j < N; j++) begin
            a_slice_s = a_slice_s | (a_r[j*DIGIT +: DIGIT] & {DIGIT{cnt_r == CW'(j)}});
            b_slice_s = b_slice_s | (b_r[j*DIGIT +: DIGIT] & {DIGIT{cnt_r == CW'(j)}});
        end
    end

    // Ripple of DIGIT full adders built from library cells.
    assign chain_s[0] = carry_r;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic p_s;
        logic g_s;
        logic t_s;
        my_xor u_xor_p (.a(a_slice_s[i]), .b(b_slice_s[i]), .y(p_s));
        my_xor u_xor_s (.a(p_s),          .b(chain_s[i]),   .y(slice_sum_s[i]));
        my_and u_and_g (.a(a_slice_s[i]), .b(b_slice_s[i]), .y(g_s));
        my_and u_and_t (.a(p_s),          .b(chain_s[i]),   .y(t_s));
        my_or  u_or_c  (.a(g_s),          .b(t_s),          .y(chain_s[i+1]));
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    my_xor u_xor_ovf (.a(chain_s[DIGIT-1]), .b(chain_s[DIGIT]), .y(ovf_s));

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (accept_s) begin
            // Subtract is a + ~b + 1: invert B and force the first carry in.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            cnt_r   <= {CW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else if (state_r == RUN) begin
            for (int j = 0; j < N; j++) begin
                if (cnt_r == CW'(j)) begin
                    sum_r[j*DIGIT +: DIGIT] <= slice_sum_s;
                end
            end
            carry_r <= chain_s[DIGIT];
            if (last_s) begin
                cnt_r  <= {CW{1'b0}};
                cout_r <= chain_s[DIGIT];
                ovf_r  <= ovf_s;
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + CW'(1);
                busy_r <= 1'b1;
                done_r <= 1'b0;
            end
        end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_my_seq_adder.sv
// Self-checking bench for my_seq_adder: directed vectors, random operations
// against an arithmetic reference model, handshake corner cases, mid-run reset
// and a DIGIT sweep (1 and 16) on extra instances sharing the same inputs.
module tb_my_seq_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;

    logic        busy4, done4, cout4, ovf4;
    logic [15:0] sum4;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] sum1;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    my_seq_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    my_seq_adder #(.WIDTH(16), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    my_seq_adder #(.WIDTH(16), .DIGIT(16)) dut_d16 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    // Reference: plain two's-complement arithmetic, result packed {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        logic [15:0] opb;
        logic [16:0] full;
        logic        o;
        opb  = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, opb} + {16'h0000, (msub ? 1'b1 : mcin)};
        o    = (ma[15] == opb[15]) && (full[15] != ma[15]);
        return {o, full[16], full[15:0]};
    endfunction

    // Issue one operation on the shared inputs and wait (bounded) for done4.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                          input logic tsub, output logic [17:0] res, output int lat,
                          output bit busy_bad);
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        busy_bad = 1'b0;
        while (done4 !== 1'b1 && lat < 100) begin
            if (busy4 !== 1'b1) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (busy4 !== 1'b0) busy_bad = 1'b1;
        res = {ovf4, cout4, sum4};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: busy=%b done=%b, required 0 0", busy4, done4);
        end
        n_checks++;
        if ({ovf4, cout4, sum4} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ovf=%b cout=%b sum=%h, required 0 0 0000", ovf4, cout4, sum4);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] va[7]  = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000, 16'hA5A5};
        logic [15:0] vb[7]  = '{16'h4321, 16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h5A5B};
        logic        vc[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        vs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [17:0] ve[7]  = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                                {2'b00, 16'h1235}, {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF},
                                {2'b01, 16'h0000}};
        logic [17:0] res;
        int          lat;
        bit          bb;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vc[i], vs[i], res, lat, bb);
            n_checks++;
            if (res !== ve[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: {ovf,cout,sum}=%h, required %h", i, res, ve[i]);
            end
            n_checks++;
            if (lat != 4 || bb) begin
                n_fail++;
                $display("FAIL directed_latency_%0d: latency=%0d busy_bad=%0d, required 4 0", i, lat, bb);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        logic        rc, rs;
        logic [17:0] res, exp_v;
        int          lat;
        bit          bb;
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            exp_v = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, res, lat, bb);
            n_checks++;
            if (res !== exp_v || lat != 4 || bb) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got %h lat=%0d, required %h lat=4",
                         i, ra, rb, rc, rs, res, lat, exp_v);
            end
            @(negedge clk);
            n_checks++;
            if (done4 !== 1'b0) begin
                n_fail++;
                $display("FAIL done_width_%0d: done=%b one cycle after pulse, required 0", i, done4);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (done4 !== 1'b1 && lat < 100) begin
            a = 16'($urandom); b = 16'($urandom); sub = ~sub; cin = ~cin;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_checks++;
        if ({ovf4, cout4, sum4} !== {2'b00, 16'h3333} || lat != 4) begin
            n_fail++;
            $display("FAIL start_while_busy: {ovf,cout,sum}=%h lat=%0d, required 03333 lat=4",
                     {ovf4, cout4, sum4}, lat);
        end
        @(negedge clk);
        n_checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_while_busy_idle: done=%b busy=%b, required 0 0", done4, busy4);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] res;
        int          lat;
        bit          bb;
        run_op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, res, lat, bb);
        n_checks++;
        if (res !== {2'b01, 16'h0000} || lat != 4) begin
            n_fail++;
            $display("FAIL b2b_first: {ovf,cout,sum}=%h lat=%0d, required 10000 lat=4", res, lat);
        end
        // Still in the DONE cycle: present the next request.
        a = 16'h0100; b = 16'h0001; cin = 1'b0; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: done=%b busy=%b, required 0 1", done4, busy4);
        end
        lat = 0;
        while (done4 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if ({ovf4, cout4, sum4} !== {2'b01, 16'h00FF} || lat != 4) begin
            n_fail++;
            $display("FAIL b2b_second: {ovf,cout,sum}=%h lat=%0d, required 100FF lat=4",
                     {ovf4, cout4, sum4}, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] res;
        int          lat;
        bit          bb;
        bit          saw_done;
        @(negedge clk);
        a = 16'h4444; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || {ovf4, cout4, sum4} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b ovf=%b cout=%b sum=%h, required all 0",
                     busy4, done4, ovf4, cout4, sum4);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: done pulse seen after abort, required none");
        end
        run_op(16'h4444, 16'h1111, 1'b0, 1'b1, res, lat, bb);
        n_checks++;
        if (res !== model(16'h4444, 16'h1111, 1'b0, 1'b1) || lat != 4) begin
            n_fail++;
            $display("FAIL reset_mid_recover: {ovf,cout,sum}=%h lat=%0d, required %h lat=4",
                     res, lat, model(16'h4444, 16'h1111, 1'b0, 1'b1));
        end
    endtask

    task automatic test_param_sweep();
        int          lat, l1, l16;
        logic [17:0] r1, r16;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a = 16'hA5A5; b = 16'h5A5B; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; l1 = -1; l16 = -1; r1 = 18'h0; r16 = 18'h0;
        while ((l1 < 0 || l16 < 0) && lat < 60) begin
            if (done1 === 1'b1 && l1 < 0) begin
                l1 = lat; r1 = {ovf1, cout1, sum1};
            end
            if (done16 === 1'b1 && l16 < 0) begin
                l16 = lat; r16 = {ovf16, cout16, sum16};
            end
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (r1 !== {2'b01, 16'h0000} || l1 != 16) begin
            n_fail++;
            $display("FAIL sweep_digit1: {ovf,cout,sum}=%h lat=%0d, required 10000 lat=16", r1, l1);
        end
        n_checks++;
        if (r16 !== {2'b01, 16'h0000} || l16 != 1) begin
            n_fail++;
            $display("FAIL sweep_digit16: {ovf,cout,sum}=%h lat=%0d, required 10000 lat=1", r16, l16);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
